// File: rtl/q15_pkg.sv
// Shared definitions for the Q-format datapath (divider and saturating adder).
package q15_pkg;

   // Default number of fractional bits for the Q format used across the datapath.
   localparam int Q15_FRAC_BITS = 15;

   // Widest operand the saturation helpers can describe.
   localparam int Q15_MAX_W = 256;

   // Divider control states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } q15_state_e;

   // Largest positive two's-complement value of a w-bit word (0x7FF..F).
   function automatic logic [Q15_MAX_W-1:0] q15_sat_pos(input int w);
      return (Q15_MAX_W'(1) << (w - 1)) - Q15_MAX_W'(1);
   endfunction

   // Most negative two's-complement value of a w-bit word (0x800..0).
   function automatic logic [Q15_MAX_W-1:0] q15_sat_neg(input int w);
      return Q15_MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/q15_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits, and report the quotient bit.
module q15_div_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // The remainder is always below the divisor, so the shifted value never
   // needs more than WIDTH+1 bits; the extra bit only keeps the math honest.
   always_comb begin
      shifted = {rem_i, bit_i};
      trial   = shifted - {2'b00, dvs_i};
      q_o     = (shifted >= {2'b00, dvs_i});
      rem_o   = q_o ? (WIDTH+1)'(trial) : (WIDTH+1)'(shifted);
   end

endmodule

// File: rtl/q15_divider.sv
// Multi-cycle signed Q-format divider: res = (a << FRAC_BITS) / b, truncated
// toward zero, saturated on overflow and on divide-by-zero.
module q15_divider
   import q15_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int FRAC_BITS = Q15_FRAC_BITS
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int N  = WIDTH + FRAC_BITS;
   localparam int CW = $clog2(N + 1);

   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(q15_sat_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(q15_sat_neg(WIDTH));
   // Quotient magnitude limits, zero-extended to the full quotient width.
   localparam logic [N-1:0]     LIM_POS = N'(SAT_POS);
   localparam logic [N-1:0]     LIM_NEG = N'(SAT_NEG);

   q15_state_e       state_q, state_d;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
   // after N steps this register holds the unsigned quotient.
   logic [N-1:0]     div_q, div_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_q, sign_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ovf_q, ovf_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] a_mag, b_mag, q_lo;
   logic [WIDTH:0]   step_rem;
   logic             step_q;

   // Magnitudes as unsigned W-bit values; |-2^(W-1)| wraps to exactly 2^(W-1).
   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;
   assign q_lo  = div_q[WIDTH-1:0];

   q15_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .bit_i (div_q[N-1]),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // Next-state, datapath and result selection.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
               div_d   = N'(a_mag) << FRAC_BITS;
               dvs_d   = b_mag;
               rem_d   = '0;
               cnt_d   = '0;
               zero_d  = (b == '0);
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (zero_q) begin
               // b is zero so the latched sign is just the sign of a.
               res_d   = sign_q ? SAT_NEG : SAT_POS;
               ovf_d   = 1'b0;
               dbz_d   = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q == CW'(N)) begin
               dbz_d = 1'b0;
               if (!sign_q && (div_q > LIM_POS)) begin
                  res_d = SAT_POS;
                  ovf_d = 1'b1;
               end else if (sign_q && (div_q > LIM_NEG)) begin
                  res_d = SAT_NEG;
                  ovf_d = 1'b1;
               end else begin
                  res_d = sign_q ? -q_lo : q_lo;
                  ovf_d = 1'b0;
               end
               state_d = ST_DONE;
            end else begin
               rem_d = step_rem;
               div_d = {div_q[N-2:0], step_q};
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign out_valid   = (state_q == ST_DONE);
   assign res         = res_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_q15_divider.sv
// Directed bench for q15_divider: vector table plus stall and reset sequences.
module tb_q15_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] res;
   logic        overflow;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   q15_divider dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .res         (res),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        ovf;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Accept one operation, scramble the operand inputs, then count cycles to out_valid.
   task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v, output int lat);
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      a = ta;
      b = tb_v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [63:0] held;

      vecs[0] = '{64'h18000, 64'h10000, 64'hC000, 1'b0, 1'b0, 80};
      vecs[1] = '{64'h8000, 64'h18000, 64'h2AAA, 1'b0, 1'b0, 80};
      vecs[2] = '{-64'sh8000, 64'h18000, 64'hFFFF_FFFF_FFFF_D556, 1'b0, 1'b0, 80};
      vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 80};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 80};
      vecs[5] = '{-64'sd5, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1};
      vecs[6] = '{64'd5, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1};
      vecs[7] = '{-64'sh18000, 64'h10000, -64'sh0C000, 1'b0, 1'b0, 80};

      // Reset state.
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_res", res, 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_res", i), res, vecs[i].res);
         chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
         chk($sformatf("v%0d_div_by_zero", i), 64'(div_by_zero), 64'(vecs[i].dbz));
         drain();
         chk($sformatf("v%0d_in_ready_after", i), 64'(in_ready), 64'd1);
      end

      // Stall in DONE: outputs hold, new operands are ignored.
      do_op(64'h18000, 64'h10000, lat);
      chk("stall_latency", 64'(lat), 64'd80);
      held = res;
      chk("stall_res_start", held, 64'hC000);
      in_valid = 1'b1;
      a = 64'h1234;
      b = 64'd0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_res", res, held);
         chk("stall_flags", {62'd0, overflow, div_by_zero}, 64'd0);
      end
      in_valid = 1'b0;
      drain();
      chk("stall_release_in_ready", 64'(in_ready), 64'd1);
      chk("stall_release_out_valid", 64'(out_valid), 64'd0);

      // Asynchronous reset mid-calculation.
      in_valid = 1'b1;
      a = 64'h8000;
      b = 64'h18000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (40) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_res", res, 64'd0);
      chk("midrst_flags", {62'd0, overflow, div_by_zero}, 64'd0);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      for (int c = 0; c < 90; c++) begin
         if (out_valid) lat++;
         @(posedge clk);
         #1;
      end
      chk("midrst_no_out_valid", 64'(lat), 64'd0);
      do_op(64'h18000, 64'h10000, lat);
      chk("postrst_latency", 64'(lat), 64'd80);
      chk("postrst_res", res, 64'hC000);
      chk("postrst_flags", {62'd0, overflow, div_by_zero}, 64'd0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
